alu_issue_ctrl: RTL and testbench

Sequential front end that drives the 32-bit MIPS ALU: accepts one instruction per valid/ready handshake, reads rs/rt from an internal 32x32 register file and presents instruction/reg1/reg2 to the ALU. It then captures final_result/flag and commits the outcome: register writeback, branch decision, address generation or overflow exception. It sits between fetch and the combinational ALU.

---
 rtl/alu_issue_pkg.sv | 67 ++++++
 rtl/regfile_2r1w.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 179 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - opcodes, functs, flag indices, FSM/commit enums and field helpers for alu_issue_ctrl
package alu_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_NEG  = 0;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, COMMIT} state_e;

  // Outcome chosen in CAPTURE and replayed as a single pulse in COMMIT.
  typedef enum logic [2:0] {K_NONE, K_WB, K_BR, K_AGU, K_OVF, K_ILL} kind_e;

  function automatic logic [5:0] f_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

  function automatic logic [15:0] f_imm16(input logic [31:0] instr);
    return instr[15:0];
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - NREGS x XLEN register file, two async reads, one sync write, r0 reads zero
module regfile_2r1w #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : r_mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : r_mem[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - 4-cycle issue/capture/commit front end for the MIPS ALU
// Optional ALU_ISSUE_STATS_EN adds retired_count/ovf_count outputs.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [31:0]     alu_instruction,
  output logic [XLEN-1:0] alu_reg1,
  output logic [XLEN-1:0] alu_reg2,
  input  logic [XLEN-1:0] alu_result,
  input  logic [2:0]      alu_flag,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            branch_taken,
  output logic [31:0]     branch_offset,
  output logic            agu_valid,
  output logic            agu_is_store,
  output logic [XLEN-1:0] agu_addr,
  output logic [XLEN-1:0] agu_store_data,
  output logic            exc_ovf,
  output logic            exc_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]     retired_count,
  output logic [15:0]     ovf_count
`endif
);

  state_e          r_state, w_next;
  kind_e           r_kind, w_kind;
  logic [4:0]      w_dest;
  logic            w_accept, w_commit;
  logic [XLEN-1:0] w_rd1, w_rd2;
  logic [31:0]     r_alu_instr;
  logic [XLEN-1:0] r_alu_reg1, r_alu_reg2;
  logic [4:0]      r_wb_addr;
  logic [XLEN-1:0] r_wb_data, r_agu_addr, r_agu_store_data;
  logic [31:0]     r_branch_offset;
  logic            r_agu_is_store;
  logic            w_unused_flag_neg;

  assign w_unused_flag_neg = alu_flag[FLAG_NEG];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (instr_valid) w_next = ISSUE;
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign instr_ready = (r_state == IDLE);
  assign w_accept    = instr_valid && instr_ready;
  assign w_commit    = (r_state == COMMIT);

  // Operands are read straight from the incoming word, so the previous commit's write is already visible.
  regfile_2r1w #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_valid),
    .waddr  (r_wb_addr),
    .wdata  (r_wb_data),
    .raddr1 (f_rs(instr)),
    .raddr2 (f_rt(instr)),
    .rdata1 (w_rd1),
    .rdata2 (w_rd2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_instr <= '0;
      r_alu_reg1  <= '0;
      r_alu_reg2  <= '0;
    end else if (w_accept) begin
      r_alu_instr <= instr;
      r_alu_reg1  <= w_rd1;
      r_alu_reg2  <= w_rd2;
    end
  end

  always_comb begin
    w_kind = K_ILL;
    w_dest = f_rd(r_alu_instr);
    case (f_opcode(r_alu_instr))
      OP_RTYPE: begin
        case (f_funct(r_alu_instr))
          FN_ADD, FN_SUB:
            w_kind = alu_flag[FLAG_OVF] ? K_OVF : K_WB;
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
            w_kind = K_WB;
          default: w_kind = K_ILL;
        endcase
      end
      OP_ADDI: begin
        w_kind = alu_flag[FLAG_OVF] ? K_OVF : K_WB;
        w_dest = f_rt(r_alu_instr);
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        w_kind = K_WB;
        w_dest = f_rt(r_alu_instr);
      end
      OP_BEQ:       w_kind = alu_flag[FLAG_ZERO] ? K_BR : K_NONE;
      OP_BNE:       w_kind = alu_flag[FLAG_ZERO] ? K_NONE : K_BR;
      OP_LW, OP_SW: w_kind = K_AGU;
      default:      w_kind = K_ILL;
    endcase
    if ((w_kind == K_WB) && (w_dest == 5'd0)) w_kind = K_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kind           <= K_NONE;
      r_wb_addr        <= '0;
      r_wb_data        <= '0;
      r_branch_offset  <= '0;
      r_agu_is_store   <= 1'b0;
      r_agu_addr       <= '0;
      r_agu_store_data <= '0;
    end else if (r_state == CAPTURE) begin
      r_kind           <= w_kind;
      r_wb_addr        <= w_dest;
      r_wb_data        <= alu_result;
      r_branch_offset  <= {{14{r_alu_instr[15]}}, f_imm16(r_alu_instr), 2'b00};
      r_agu_is_store   <= (f_opcode(r_alu_instr) == OP_SW);
      r_agu_addr       <= alu_result;
      r_agu_store_data <= r_alu_reg2;
    end
  end

  assign alu_instruction = r_alu_instr;
  assign alu_reg1        = r_alu_reg1;
  assign alu_reg2        = r_alu_reg2;
  assign wb_valid        = w_commit && (r_kind == K_WB);
  assign branch_taken    = w_commit && (r_kind == K_BR);
  assign agu_valid       = w_commit && (r_kind == K_AGU);
  assign exc_ovf         = w_commit && (r_kind == K_OVF);
  assign exc_illegal     = w_commit && (r_kind == K_ILL);
  assign wb_addr         = r_wb_addr;
  assign wb_data         = r_wb_data;
  assign branch_offset   = r_branch_offset;
  assign agu_is_store    = r_agu_is_store;
  assign agu_addr        = r_agu_addr;
  assign agu_store_data  = r_agu_store_data;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] r_retired, r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_commit) r_retired <= r_retired + 16'd1;
      if (exc_ovf)  r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign retired_count = r_retired;
  assign ovf_count     = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic [31:0] alu_instruction, alu_reg1, alu_reg2, alu_result;
  logic [2:0]  alu_flag;
  logic        wb_valid, branch_taken, agu_valid, agu_is_store, exc_ovf, exc_illegal;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, branch_offset, agu_addr, agu_store_data;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] retired_count, ovf_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_instruction(alu_instruction),
    .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_result(alu_result),
    .alu_flag(alu_flag), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .agu_valid(agu_valid), .agu_is_store(agu_is_store), .agu_addr(agu_addr),
    .agu_store_data(agu_store_data), .exc_ovf(exc_ovf), .exc_illegal(exc_illegal)
`ifdef ALU_ISSUE_STATS_EN
    , .retired_count(retired_count), .ovf_count(ovf_count)
`endif
  );

  // Behavioural ALU: only the operations the directed vectors use.
  logic [31:0] m_res, m_imm;
  logic        m_ovf;
  always_comb begin
    m_res = '0;
    m_ovf = 1'b0;
    m_imm = {{16{alu_instruction[15]}}, alu_instruction[15:0]};
    case (alu_instruction[31:26])
      6'h00: begin
        case (alu_instruction[5:0])
          6'h20, 6'h21: begin
            m_res = alu_reg1 + alu_reg2;
            m_ovf = (alu_reg1[31] == alu_reg2[31]) && (m_res[31] != alu_reg1[31]);
          end
          6'h22, 6'h23: begin
            m_res = alu_reg1 - alu_reg2;
            m_ovf = (alu_reg1[31] != alu_reg2[31]) && (m_res[31] != alu_reg1[31]);
          end
          6'h24:   m_res = alu_reg1 & alu_reg2;
          6'h25:   m_res = alu_reg1 | alu_reg2;
          6'h00:   m_res = alu_reg2 << alu_instruction[10:6];
          default: m_res = '0;
        endcase
      end
      6'h08, 6'h09: begin
        m_res = alu_reg1 + m_imm;
        m_ovf = (alu_reg1[31] == m_imm[31]) && (m_res[31] != alu_reg1[31]);
      end
      6'h04, 6'h05: m_res = alu_reg1 - alu_reg2;
      6'h23, 6'h2B: m_res = alu_reg1 + m_imm;
      default:      m_res = '0;
    endcase
    alu_result = m_res;
    alu_flag   = {(m_res == 32'd0), m_ovf, m_res[31]};
  end

  logic any_pulse;
  assign any_pulse = wb_valid | branch_taken | agu_valid | exc_ovf | exc_illegal;

  logic        s_wbv, s_br, s_agv, s_ags, s_ovf, s_ill, s_early, s_late, s_rdy;
  logic [4:0]  s_wba;
  logic [31:0] s_wbd, s_bro, s_aga, s_agsd, s_r1, s_r2;
  int          s_np;

  // Issues one instruction from a negedge and snapshots ISSUE/CAPTURE/COMMIT/next-IDLE.
  task automatic exec(input logic [31:0] ins);
    int to = 0;
    while (!instr_ready && to < 20) begin @(negedge clk); to++; end
    if (!instr_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL exec_ready_timeout: instr_ready=%0b required 1", instr_ready);
    end
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0; instr = '0;
    @(negedge clk); s_early = any_pulse;
    @(negedge clk); s_early = s_early | any_pulse; s_r1 = alu_reg1; s_r2 = alu_reg2;
    @(negedge clk);
    s_wbv = wb_valid; s_wba = wb_addr; s_wbd = wb_data; s_br = branch_taken;
    s_bro = branch_offset; s_agv = agu_valid; s_ags = agu_is_store; s_aga = agu_addr;
    s_agsd = agu_store_data; s_ovf = exc_ovf; s_ill = exc_illegal;
    s_np = int'(wb_valid) + int'(branch_taken) + int'(agu_valid) + int'(exc_ovf) + int'(exc_illegal);
    @(negedge clk); s_rdy = instr_ready; s_late = any_pulse;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", instr_ready); end
    n_cmp++; if (any_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %0b required 0", any_pulse); end
    n_cmp++; if ({alu_instruction, alu_reg1, alu_reg2} !== 96'd0) begin n_fail++; $display("FAIL reset_alu: got %h %h %h required 0", alu_instruction, alu_reg1, alu_reg2); end
    n_cmp++; if ({wb_addr, wb_data, branch_offset, agu_addr, agu_store_data, agu_is_store} !== 134'd0) begin n_fail++; $display("FAIL reset_regs: got %h %h %h %h %h required 0", wb_addr, wb_data, branch_offset, agu_addr, agu_store_data); end
  endtask

  task automatic test_addi;
    exec(32'h2001_0005);
    n_cmp++; if ({s_wbv, s_wba, s_wbd} !== {1'b1, 5'd1, 32'd5}) begin n_fail++; $display("FAIL addi_wb: got %0b/%0d/%h required 1/1/5", s_wbv, s_wba, s_wbd); end
    n_cmp++; if (s_early !== 1'b0) begin n_fail++; $display("FAIL addi_latency: early pulse=%0b required 0", s_early); end
    n_cmp++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL addi_ready_after: got %0b required 1", s_rdy); end
    n_cmp++; if (s_np !== 1) begin n_fail++; $display("FAIL addi_onehot: got %0d pulses required 1", s_np); end
  endtask

  task automatic test_add;
    exec(32'h2001_0005);
    exec(32'h2002_0007);
    exec(32'h0022_1820);
    n_cmp++; if ({s_r1, s_r2} !== {32'd5, 32'd7}) begin n_fail++; $display("FAIL add_operands: got %h %h required 5 7", s_r1, s_r2); end
    n_cmp++; if ({s_wbv, s_wba, s_wbd} !== {1'b1, 5'd3, 32'd12}) begin n_fail++; $display("FAIL add_wb: got %0b/%0d/%h required 1/3/c", s_wbv, s_wba, s_wbd); end
  endtask

  task automatic test_overflow;
    exec(32'h2001_0001);
    exec(32'h0001_0FC0);
    n_cmp++; if (s_wbd !== 32'h8000_0000) begin n_fail++; $display("FAIL sll_wb: got %h required 80000000", s_wbd); end
    exec(32'h0021_1020);
    n_cmp++; if ({s_ovf, s_wbv, s_np} !== {1'b1, 1'b0, 32'd1}) begin n_fail++; $display("FAIL add_ovf: ovf=%0b wb=%0b n=%0d required 1/0/1", s_ovf, s_wbv, s_np); end
    exec(32'h0040_2021);
    n_cmp++; if ({s_r1, s_wbd} !== {32'd7, 32'd7}) begin n_fail++; $display("FAIL ovf_r2_kept: got %h/%h required 7/7", s_r1, s_wbd); end
    exec(32'h0021_1021);
    n_cmp++; if ({s_ovf, s_wbv, s_wba, s_wbd} !== {1'b0, 1'b1, 5'd2, 32'd0}) begin n_fail++; $display("FAIL addu_wrap: ovf=%0b wb=%0b a=%0d d=%h required 0/1/2/0", s_ovf, s_wbv, s_wba, s_wbd); end
  endtask

  task automatic test_branch_agu;
    exec(32'h1021_0003);
    n_cmp++; if ({s_br, s_bro, s_np} !== {1'b1, 32'd12, 32'd1}) begin n_fail++; $display("FAIL beq_taken: br=%0b off=%h n=%0d required 1/c/1", s_br, s_bro, s_np); end
    exec(32'h1421_0003);
    n_cmp++; if ({s_np, s_early, s_late} !== {32'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL bne_not_taken: n=%0d required 0", s_np); end
    exec(32'h1420_FFFE);
    n_cmp++; if ({s_br, s_bro} !== {1'b1, 32'hFFFF_FFF8}) begin n_fail++; $display("FAIL bne_neg_off: br=%0b off=%h required 1/fffffff8", s_br, s_bro); end
    exec(32'h8C65_0010);
    n_cmp++; if ({s_agv, s_ags, s_aga, s_wbv, s_np} !== {1'b1, 1'b0, 32'd28, 1'b0, 32'd1}) begin n_fail++; $display("FAIL lw_agu: v=%0b st=%0b a=%h wb=%0b required 1/0/1c/0", s_agv, s_ags, s_aga, s_wbv); end
    exec(32'hAC63_0004);
    n_cmp++; if ({s_agv, s_ags, s_aga, s_agsd} !== {1'b1, 1'b1, 32'd16, 32'd12}) begin n_fail++; $display("FAIL sw_agu: v=%0b st=%0b a=%h d=%h required 1/1/10/c", s_agv, s_ags, s_aga, s_agsd); end
  endtask

  task automatic test_r0_illegal;
    exec(32'h2000_0009);
    n_cmp++; if ({s_wbv, s_np} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL r0_write: wb=%0b n=%0d required 0/0", s_wbv, s_np); end
    exec(32'h0000_3021);
    n_cmp++; if ({s_r1, s_r2, s_wbd} !== 96'd0) begin n_fail++; $display("FAIL r0_reads_zero: got %h %h %h required 0", s_r1, s_r2, s_wbd); end
    exec(32'hFC00_0000);
    n_cmp++; if ({s_ill, s_np} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL illegal_op: ill=%0b n=%0d required 1/1", s_ill, s_np); end
    exec(32'h0000_0008);
    n_cmp++; if ({s_ill, s_np} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL illegal_funct: ill=%0b n=%0d required 1/1", s_ill, s_np); end
  endtask

  task automatic test_reset_midflight;
    logic seen = 1'b0;
    @(negedge clk);
    instr = 32'h0022_1820; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0; instr = '0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({any_pulse, alu_instruction, alu_reg1, wb_data} !== 97'd0) begin n_fail++; $display("FAIL midreset_outputs: pulse=%0b ins=%h r1=%h wbd=%h required 0", any_pulse, alu_instruction, alu_reg1, wb_data); end
    reset = 1'b0; #1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %0b required 1", instr_ready); end
    repeat (3) begin @(negedge clk); seen = seen | any_pulse; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_commit: got %0b required 0", seen); end
    exec(32'h0023_3821);
    n_cmp++; if ({s_r1, s_r2, s_wbv, s_wba, s_wbd} !== {32'd0, 32'd0, 1'b1, 5'd7, 32'd0}) begin n_fail++; $display("FAIL midreset_rf_cleared: r1=%h r2=%h wb=%0b a=%0d d=%h required 0/0/1/7/0", s_r1, s_r2, s_wbv, s_wba, s_wbd); end
`ifdef ALU_ISSUE_STATS_EN
    n_cmp++; if ({retired_count, ovf_count} !== {16'd1, 16'd0}) begin n_fail++; $display("FAIL stats: ret=%0d ovf=%0d required 1/0", retired_count, ovf_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_add();
    test_overflow();
    test_branch_agu();
    test_r0_illegal();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
